ipsl_pcie_seio_regif: RTL and testbench

IPSL_PCIE_SEIO_REGIF -- requirements
Module: ipsl_pcie_seio_regif

---
 rtl/ipsl_pcie_seio_regif.sv | 222 ++++++++++++++++++++++
 tb/tb_ipsl_pcie_seio_regif.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsl_pcie_seio_regif.sv
// ipsl_pcie_seio_regif: serial register-access bridge between the PCIe core's
// SEIO frame interface and a parallel register bus.
//   pclk_div2, user_rst_n      : block clock, async active-low reset
//   sedo_in, sedo_en_in        : serial frame data/enable from the core (asynchronous)
//   sedi, sedi_ack             : serial read data (MSB first) and completion pulse
//   reg_wr_en, reg_rd_en       : one-cycle register write/read strobes
//   reg_addr, reg_wdata        : register address (held) and write data
//   reg_rdata, reg_rd_valid    : register read data and its qualifier
//   seio_err                   : one-cycle pulse on framing abort or read timeout
// Optional read timeout: define IPSL_PCIE_SEIO_RD_TIMEOUT_EN.
module ipsl_pcie_seio_regif #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TO_CYCLES = 255
) (
   input  logic              pclk_div2,
   input  logic              user_rst_n,
   input  logic              sedo_in,
   input  logic              sedo_en_in,
   output logic              sedi,
   output logic              sedi_ack,
   output logic              reg_wr_en,
   output logic              reg_rd_en,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   input  logic [DATA_W-1:0] reg_rdata,
   input  logic              reg_rd_valid,
   output logic              seio_err
);

   localparam int unsigned MAX_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
   localparam int unsigned CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, CMD, WDAT, RREQ, RWAIT, RSHIFT, ACK} state_t;

   state_t            state, state_nxt;
   logic [1:0]        sync_d, sync_e;
   logic              sbit, en_s;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              op, op_nxt;
   logic [ADDR_W-1:0] addr_sh, addr_sh_nxt, addr_nxt;
   logic [DATA_W-1:0] data_sh, data_sh_nxt, wdata_nxt, data_shifted;
   logic              sedi_nxt, ack_nxt, wr_nxt, rd_nxt, err_nxt;

`ifdef IPSL_PCIE_SEIO_RD_TIMEOUT_EN
   localparam int unsigned TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
   logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
`else
   logic              unused_to;
   assign unused_to = ^32'(TO_CYCLES);
`endif

   // Two-flop synchronisers for the asynchronous serial inputs
   always_ff @(posedge pclk_div2 or negedge user_rst_n) begin
      if (!user_rst_n) begin
         sync_d <= 2'b00;
         sync_e <= 2'b00;
      end else begin
         sync_d <= {sync_d[0], sedo_in};
         sync_e <= {sync_e[0], sedo_en_in};
      end
   end

   assign sbit = sync_d[1];
   assign en_s = sync_e[1];
   assign data_shifted = (data_sh << 1) | DATA_W'(sbit);

   // Next-state and next-output logic
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      op_nxt      = op;
      addr_sh_nxt = addr_sh;
      data_sh_nxt = data_sh;
      addr_nxt    = reg_addr;
      wdata_nxt   = reg_wdata;
      sedi_nxt    = 1'b0;
      ack_nxt     = 1'b0;
      wr_nxt      = 1'b0;
      rd_nxt      = 1'b0;
      err_nxt     = 1'b0;
`ifdef IPSL_PCIE_SEIO_RD_TIMEOUT_EN
      to_cnt_nxt  = to_cnt;
`endif
      case (state)
         IDLE: begin
            if (en_s) begin
               op_nxt    = sbit;
               cnt_nxt   = '0;
               state_nxt = CMD;
            end
         end
         CMD: begin
            if (!en_s) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               addr_sh_nxt = (addr_sh << 1) | ADDR_W'(sbit);
               if (cnt == ADDR_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = op ? WDAT : RREQ;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         WDAT: begin
            if (!en_s) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == DATA_LAST) begin
               // Last data bit: strobe lands next cycle with address and data
               data_sh_nxt = data_shifted;
               wdata_nxt   = data_shifted;
               addr_nxt    = addr_sh;
               wr_nxt      = 1'b1;
               cnt_nxt     = '0;
               state_nxt   = ACK;
            end else begin
               data_sh_nxt = data_shifted;
               cnt_nxt     = cnt + CNT_W'(1);
            end
         end
         RREQ: begin
            if (!en_s) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               addr_nxt   = addr_sh;
               rd_nxt     = 1'b1;
               state_nxt  = RWAIT;
`ifdef IPSL_PCIE_SEIO_RD_TIMEOUT_EN
               to_cnt_nxt = '0;
`endif
            end
         end
         RWAIT: begin
            // reg_rd_en high marks the strobe cycle; valid then is ignored
            if (!en_s) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else if (reg_rd_valid && !reg_rd_en) begin
               sedi_nxt    = reg_rdata[DATA_W-1];
               data_sh_nxt = reg_rdata << 1;
               cnt_nxt     = '0;
               state_nxt   = RSHIFT;
`ifdef IPSL_PCIE_SEIO_RD_TIMEOUT_EN
            end else if (to_cnt == TO_LAST) begin
               err_nxt     = 1'b1;
               data_sh_nxt = '0;
               cnt_nxt     = '0;
               state_nxt   = RSHIFT;
            end else begin
               to_cnt_nxt = to_cnt + TO_W'(1);
`endif
            end
         end
         RSHIFT: begin
            // sedi is preloaded with the MSB, so it stays aligned with this state
            if (!en_s) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == DATA_LAST) begin
               cnt_nxt   = '0;
               state_nxt = ACK;
            end else begin
               sedi_nxt    = data_sh[DATA_W-1];
               data_sh_nxt = data_sh << 1;
               cnt_nxt     = cnt + CNT_W'(1);
            end
         end
         ACK: begin
            if (!en_s) begin
               ack_nxt   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge pclk_div2 or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         op        <= 1'b0;
         addr_sh   <= '0;
         data_sh   <= '0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         sedi      <= 1'b0;
         sedi_ack  <= 1'b0;
         reg_wr_en <= 1'b0;
         reg_rd_en <= 1'b0;
         seio_err  <= 1'b0;
`ifdef IPSL_PCIE_SEIO_RD_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         op        <= op_nxt;
         addr_sh   <= addr_sh_nxt;
         data_sh   <= data_sh_nxt;
         reg_addr  <= addr_nxt;
         reg_wdata <= wdata_nxt;
         sedi      <= sedi_nxt;
         sedi_ack  <= ack_nxt;
         reg_wr_en <= wr_nxt;
         reg_rd_en <= rd_nxt;
         seio_err  <= err_nxt;
`ifdef IPSL_PCIE_SEIO_RD_TIMEOUT_EN
         to_cnt    <= to_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_ipsl_pcie_seio_regif.sv
// Bench for ipsl_pcie_seio_regif: directed and random frames against a
// transaction-level expectation of strobes, acks, errors and serial read data.
module tb_ipsl_pcie_seio_regif;
   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned TO_CYCLES = 255;
   localparam int unsigned FR_W      = 1 + ADDR_W + DATA_W;

   logic              pclk_div2 = 1'b0;
   logic              user_rst_n = 1'b0;
   logic              sedo_in = 1'b0, sedo_en_in = 1'b0;
   logic              sedi, sedi_ack, reg_wr_en, reg_rd_en, seio_err;
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdata;
   logic [DATA_W-1:0] reg_rdata = '0;
   logic              reg_rd_valid = 1'b0;

   int checks = 0, errors = 0;
   int n_wr = 0, n_rd = 0, n_ack = 0, n_err = 0, n_long = 0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [DATA_W-1:0] wr_data = '0;
   logic p_wr = 0, p_rd = 0, p_ack = 0, p_err = 0;

   always #5 pclk_div2 = ~pclk_div2;

   ipsl_pcie_seio_regif #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TO_CYCLES(TO_CYCLES)) dut (
      .pclk_div2(pclk_div2), .user_rst_n(user_rst_n),
      .sedo_in(sedo_in), .sedo_en_in(sedo_en_in),
      .sedi(sedi), .sedi_ack(sedi_ack),
      .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .reg_rd_valid(reg_rd_valid),
      .seio_err(seio_err));

   // Pulse monitor: counts every strobe and flags any that lasts over one cycle
   always @(negedge pclk_div2) begin
      if (reg_wr_en) begin n_wr++; wr_addr = reg_addr; wr_data = reg_wdata; end
      if (reg_rd_en) n_rd++;
      if (sedi_ack)  n_ack++;
      if (seio_err)  n_err++;
      if ((reg_wr_en && p_wr) || (reg_rd_en && p_rd) || (sedi_ack && p_ack) || (seio_err && p_err))
         n_long++;
      p_wr = reg_wr_en; p_rd = reg_rd_en; p_ack = sedi_ack; p_err = seio_err;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      @(negedge pclk_div2);
      sedo_en_in = 1'b1;
      sedo_in    = b;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge pclk_div2);
         sedo_en_in = 1'b0;
         sedo_in    = 1'($urandom);
      end
   endtask

   task automatic send_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int nbits);
      logic [FR_W-1:0] fr;
      fr = {1'b1, a, d};
      for (int i = 0; i < nbits; i++) drive_bit(fr[FR_W-1-i]);
   endtask

   // Write frame of nbits bits; a full frame writes and acks, a short one aborts
   task automatic do_write(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input int nbits);
      int w0, a0, e0;
      w0 = n_wr; a0 = n_ack; e0 = n_err;
      send_write(a, d, nbits);
      idle(8);
      if (nbits == int'(FR_W)) begin
         chk({tag, "_wr"},    64'(n_wr - w0), 64'd1);
         chk({tag, "_addr"},  64'(wr_addr), 64'(a));
         chk({tag, "_data"},  64'(wr_data), 64'(d));
         chk({tag, "_ack"},   64'(n_ack - a0), 64'd1);
         chk({tag, "_noerr"}, 64'(n_err - e0), 64'd0);
         chk({tag, "_hold"},  64'(reg_addr), 64'(a));
      end else begin
         chk({tag, "_nowr"},  64'(n_wr - w0), 64'd0);
         chk({tag, "_noack"}, 64'(n_ack - a0), 64'd0);
         chk({tag, "_err"},   64'(n_err - e0), 64'd1);
      end
   endtask

   // Read command bits then wait (en high) for the strobe
   task automatic start_read(input string tag, input logic [ADDR_W-1:0] a);
      logic [ADDR_W:0] fr;
      int t;
      fr = {1'b0, a};
      for (int i = 0; i <= int'(ADDR_W); i++) drive_bit(fr[ADDR_W-i]);
      t = 0;
      while (!reg_rd_en && t < 30) begin
         @(negedge pclk_div2);
         sedo_in = 1'($urandom);
         t++;
      end
      chk({tag, "_rden"}, 64'(reg_rd_en), 64'd1);
      chk({tag, "_raddr"}, 64'(reg_addr), 64'(a));
      // valid in the strobe cycle carries a decoy word that must be ignored
      reg_rd_valid = 1'b1;
      reg_rdata    = ~reg_rdata;
   endtask

   task automatic do_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int dly);
      int r0, a0, e0;
      logic [DATA_W-1:0] got;
      r0 = n_rd; a0 = n_ack; e0 = n_err;
      reg_rdata = d;
      start_read(tag, a);
      @(negedge pclk_div2);
      reg_rd_valid = 1'b0;
      repeat (dly - 1) @(negedge pclk_div2);
      chk({tag, "_sedi_pre"}, 64'(sedi), 64'd0);
      reg_rd_valid = 1'b1;
      reg_rdata    = d;
      @(negedge pclk_div2);
      reg_rd_valid = 1'b0;
      reg_rdata    = DATA_W'($urandom);
      for (int i = 0; i < int'(DATA_W); i++) begin
         got[DATA_W-1-i] = sedi;
         @(negedge pclk_div2);
      end
      chk({tag, "_word"}, 64'(got), 64'(d));
      chk({tag, "_sedi_post"}, 64'(sedi), 64'd0);
      idle(8);
      chk({tag, "_rd"},    64'(n_rd - r0), 64'd1);
      chk({tag, "_ack"},   64'(n_ack - a0), 64'd1);
      chk({tag, "_noerr"}, 64'(n_err - e0), 64'd0);
   endtask

   task automatic do_read_abort(input string tag, input logic [ADDR_W-1:0] a, input int nbits);
      logic [ADDR_W:0] fr;
      int r0, a0, e0;
      r0 = n_rd; a0 = n_ack; e0 = n_err;
      fr = {1'b0, a};
      for (int i = 0; i < nbits; i++) drive_bit(fr[ADDR_W-i]);
      idle(8);
      chk({tag, "_nord"},  64'(n_rd - r0), 64'd0);
      chk({tag, "_noack"}, 64'(n_ack - a0), 64'd0);
      chk({tag, "_err"},   64'(n_err - e0), 64'd1);
   endtask

   initial begin
      int r0, a0, e0, w0;
      logic [DATA_W-1:0] rd0;

      // reset state
      repeat (3) @(negedge pclk_div2);
      chk("reset_outs", 64'({sedi, sedi_ack, reg_wr_en, reg_rd_en, seio_err, reg_addr, reg_wdata}), 64'd0);
      user_rst_n = 1'b1;
      idle(4);
      chk("idle_outs", 64'({sedi, sedi_ack, reg_wr_en, reg_rd_en, seio_err}), 64'd0);

      do_write("wr_dir", 8'h3C, 32'hA5A5_0F0F, int'(FR_W));
      do_read("rd_dir", 8'h10, 32'h1234_5678, 3);
      do_write("wr_abort20", 8'h55, 32'hFFFF_FFFF, 1 + int'(ADDR_W) + 20);
      do_write("wr_after_abort", 8'hC3, 32'h0BAD_F00D, int'(FR_W));
      do_write("wr_abort_op", 8'hFF, 32'h0, 1);
      do_write("wr_abort_last", 8'hAA, 32'h1, int'(FR_W) - 1);
      do_read_abort("rd_abort_rreq", 8'h77, int'(ADDR_W) + 1);

      for (int k = 0; k < 6; k++)
         do_write("wr_rnd", ADDR_W'($urandom), DATA_W'($urandom), int'(FR_W));
      for (int k = 0; k < 4; k++)
         do_read("rd_rnd", ADDR_W'($urandom), DATA_W'($urandom), int'($urandom_range(2, 6)));
      for (int k = 0; k < 4; k++)
         do_write("wr_abort_rnd", ADDR_W'($urandom), DATA_W'($urandom), int'($urandom_range(1, FR_W - 1)));
      do_read_abort("rd_abort_rnd", ADDR_W'($urandom), int'($urandom_range(1, ADDR_W)));

      // back-to-back writes separated by a single low-enable cycle
      w0 = n_wr; a0 = n_ack;
      send_write(8'h01, 32'h1111_2222, int'(FR_W));
      idle(1);
      send_write(8'h02, 32'h3333_4444, int'(FR_W));
      idle(8);
      chk("b2b_wr", 64'(n_wr - w0), 64'd2);
      chk("b2b_ack", 64'(n_ack - a0), 64'd2);
      chk("b2b_data", 64'({wr_addr, wr_data}), 64'({8'h02, 32'h3333_4444}));

      // framing abort while waiting for read data
      r0 = n_rd; a0 = n_ack; e0 = n_err;
      start_read("rd_abort_wait", 8'h42);
      @(negedge pclk_div2);
      reg_rd_valid = 1'b0;
      idle(8);
      chk("rd_abort_wait_rd", 64'(n_rd - r0), 64'd1);
      chk("rd_abort_wait_err", 64'(n_err - e0), 64'd1);
      chk("rd_abort_wait_noack", 64'(n_ack - a0), 64'd0);

`ifdef IPSL_PCIE_SEIO_RD_TIMEOUT_EN
      begin
         int t;
         logic acc;
         r0 = n_rd; a0 = n_ack; e0 = n_err;
         start_read("rd_to", 8'h5A);
         t = 0;
         acc = 1'b0;
         while (!seio_err && t < 400) begin
            @(negedge pclk_div2);
            reg_rd_valid = 1'b0;
            sedo_in = 1'($urandom);
            t++;
         end
         chk("rd_to_cycle", 64'(t), 64'(TO_CYCLES));
         for (int i = 0; i < int'(DATA_W); i++) begin
            acc = acc | sedi;
            @(negedge pclk_div2);
         end
         chk("rd_to_sedi_zero", 64'(acc), 64'd0);
         idle(8);
         chk("rd_to_err", 64'(n_err - e0), 64'd1);
         chk("rd_to_ack", 64'(n_ack - a0), 64'd1);
      end
`endif

      // reset in the middle of the serial read-out
      r0 = n_rd; a0 = n_ack; e0 = n_err;
      rd0 = 32'hFFFF_FFFF;
      reg_rdata = rd0;
      start_read("rd_rst", 8'hE1);
      @(negedge pclk_div2);
      reg_rd_valid = 1'b0;
      @(negedge pclk_div2);
      reg_rd_valid = 1'b1;
      reg_rdata    = rd0;
      repeat (5) @(negedge pclk_div2);
      reg_rd_valid = 1'b0;
      chk("rd_rst_shifting", 64'(sedi), 64'd1);
      user_rst_n = 1'b0;
      sedo_en_in = 1'b0;
      #1;
      chk("rst_mid_outs", 64'({sedi, sedi_ack, reg_wr_en, reg_rd_en, seio_err, reg_addr, reg_wdata}), 64'd0);
      repeat (3) @(negedge pclk_div2);
      user_rst_n = 1'b1;
      idle(6);
      chk("rst_mid_noack", 64'(n_ack - a0), 64'd0);
      chk("rst_mid_noerr", 64'(n_err - e0), 64'd0);
      do_write("wr_after_rst", 8'h9D, 32'hCAFE_BABE, int'(FR_W));

      chk("pulse_width", 64'(n_long), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
